// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one 32-bit word read or write per bus request.
// Optional macro SRAM_CTRL_RD_REG_EN registers read data and adds an RD_ACK cycle.
module sram_ctrl #(
    parameter int unsigned AW      = 18,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stb,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          ack,
    output logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_dq_in,
    output logic [31:0]   sram_dq_out,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
`ifdef SRAM_CTRL_RD_REG_EN
        RD_ACK,
`endif
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
`ifdef SRAM_CTRL_RD_REG_EN
    logic [31:0]   rd_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
`ifdef SRAM_CTRL_RD_REG_EN
            rd_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (stb) begin
                        addr_q <= addr;
                        data_q <= data_in;
                        if (we) begin
                            state <= WR_SETUP;
                            cnt   <= 4'(WR_WAIT - 1);
                        end else begin
                            state <= RD;
                            cnt   <= 4'(RD_WAIT);
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
`ifdef SRAM_CTRL_RD_REG_EN
                        rd_q  <= sram_dq_in;
                        state <= RD_ACK;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`ifdef SRAM_CTRL_RD_REG_EN
                RD_ACK:   state <= IDLE;
`endif
                // Counter holds WR_WAIT-1 through setup so the pulse spans WR_WAIT cycles.
                WR_SETUP: state <= WR_PULSE;
                WR_PULSE: begin
                    if (cnt == '0) state <= WR_HOLD;
                    else           cnt   <= cnt - 4'd1;
                end
                WR_HOLD:  state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        ack        = 1'b0;
        case (state)
            RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
`ifndef SRAM_CTRL_RD_REG_EN
                ack       = (cnt == '0);
`endif
            end
`ifdef SRAM_CTRL_RD_REG_EN
            RD_ACK: ack = 1'b1;
`endif
            WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                ack        = 1'b1;
            end
            default: ;
        endcase
    end

    assign sram_addr   = addr_q;
    assign sram_dq_out = data_q;
`ifdef SRAM_CTRL_RD_REG_EN
    assign data_out    = rd_q;
`else
    assign data_out    = sram_dq_in;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl at default parameters, either macro build.
module tb_sram_ctrl;

    localparam int AW      = 18;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
`ifdef SRAM_CTRL_RD_REG_EN
    localparam int RD_ACK_CYC = RD_WAIT + 2;
`else
    localparam int RD_ACK_CYC = RD_WAIT + 1;
`endif
    localparam int WR_ACK_CYC = WR_WAIT + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic          ack;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dq_in;
    logic [31:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.AW(AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b1; we = 1'b0; addr = 18'h00005;
        data_in = '0; sram_dq_in = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            n_cmp++;
            if ({ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 5'b01110) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: ack/ce/oe/we/oe_drv=%b want 01110", i,
                         {ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
            end
        end
        // cycle 0: reset released, still IDLE, accepted at the end of this cycle
        cyc(); rst = 1'b0; #2;
        n_cmp++;
        if (sram_oe_n !== 1'b1 || ack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: oe_n=%b ack=%b want 1 0", sram_oe_n, ack);
        end
        for (int c = 1; c <= RD_ACK_CYC + 1; c++) begin
            cyc();
            if (c == RD_ACK_CYC + 1) stb = 1'b0;
            #2;
            n_cmp++;
            if (ack !== (c == RD_ACK_CYC)) begin
                n_bad++;
                $display("FAIL reset_first_read ack cyc%0d: got %b want %b", c, ack, c == RD_ACK_CYC);
            end
            if (c == 1) begin
                n_cmp++;
                if (sram_oe_n !== 1'b0 || sram_addr !== 18'h00005) begin
                    n_bad++;
                    $display("FAIL reset_first_read start: oe_n=%b addr=%h want 0 00005", sram_oe_n, sram_addr);
                end
            end
            if (c == RD_ACK_CYC) begin
                n_cmp++;
                if (data_out !== 32'h0000_0055) begin
                    n_bad++;
                    $display("FAIL reset_first_read data: got %h want 00000055", data_out);
                end
            end
        end
    endtask

    task automatic test_read();
        cyc();
        stb = 1'b1; we = 1'b0; addr = 18'h00010; sram_dq_in = 32'hDEADBEEF;
        #2;
        n_cmp++;
        if (ack !== 1'b0 || sram_oe_n !== 1'b1 || sram_ce_n !== 1'b1) begin
            n_bad++;
            $display("FAIL read_c0: ack=%b oe_n=%b ce_n=%b want 0 1 1", ack, sram_oe_n, sram_ce_n);
        end
        for (int c = 1; c <= RD_ACK_CYC + 1; c++) begin
            logic exp_oe_n;
            cyc();
`ifdef SRAM_CTRL_RD_REG_EN
            if (c == RD_ACK_CYC) sram_dq_in = 32'h0;
`endif
            if (c == RD_ACK_CYC + 1) stb = 1'b0;
            #2;
            exp_oe_n = !(c >= 1 && c <= RD_WAIT + 1);
            n_cmp++;
            if (sram_oe_n !== exp_oe_n || sram_ce_n !== exp_oe_n || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
                n_bad++;
                $display("FAIL read_strobes cyc%0d: oe_n=%b ce_n=%b we_n=%b dq_oe=%b want oe_n=ce_n=%b we_n=1 dq_oe=0",
                         c, sram_oe_n, sram_ce_n, sram_we_n, sram_dq_oe, exp_oe_n);
            end
            n_cmp++;
            if (ack !== (c == RD_ACK_CYC)) begin
                n_bad++;
                $display("FAIL read_ack cyc%0d: got %b want %b", c, ack, c == RD_ACK_CYC);
            end
            if (!exp_oe_n) begin
                n_cmp++;
                if (sram_addr !== 18'h00010) begin
                    n_bad++;
                    $display("FAIL read_addr cyc%0d: got %h want 00010", c, sram_addr);
                end
            end
            if (c == RD_ACK_CYC) begin
                n_cmp++;
                if (data_out !== 32'hDEADBEEF) begin
                    n_bad++;
                    $display("FAIL read_data: got %h want deadbeef", data_out);
                end
            end
        end
    endtask

    task automatic test_write();
        cyc();
        stb = 1'b1; we = 1'b1; addr = 18'h3FFFF; data_in = 32'h12345678;
        #2;
        for (int c = 1; c <= WR_ACK_CYC + 1; c++) begin
            logic exp_oe, exp_we_n;
            cyc();
            if (c == WR_ACK_CYC + 1) stb = 1'b0;
            #2;
            exp_oe   = (c >= 1 && c <= WR_WAIT + 2);
            exp_we_n = !(c >= 2 && c <= WR_WAIT + 1);
            n_cmp++;
            if (sram_dq_oe !== exp_oe || sram_we_n !== exp_we_n || sram_oe_n !== 1'b1 || sram_ce_n !== !exp_oe) begin
                n_bad++;
                $display("FAIL write_strobes cyc%0d: dq_oe=%b we_n=%b oe_n=%b ce_n=%b want %b %b 1 %b",
                         c, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, exp_oe, exp_we_n, !exp_oe);
            end
            n_cmp++;
            if (ack !== (c == WR_ACK_CYC)) begin
                n_bad++;
                $display("FAIL write_ack cyc%0d: got %b want %b", c, ack, c == WR_ACK_CYC);
            end
            if (exp_oe) begin
                n_cmp++;
                if (sram_dq_out !== 32'h12345678 || sram_addr !== 18'h3FFFF) begin
                    n_bad++;
                    $display("FAIL write_bus cyc%0d: dq=%h addr=%h want 12345678 3ffff", c, sram_dq_out, sram_addr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int clash = 0;
        cyc();
        stb = 1'b1; we = 1'b0; addr = 18'h00021; sram_dq_in = 32'h0F0F_0F0F; data_in = '0;
        #2;
        for (int c = 1; c <= RD_ACK_CYC + WR_WAIT + 6; c++) begin
            cyc();
            if (c == RD_ACK_CYC + 1) begin
                we = 1'b1; addr = 18'h00022; data_in = 32'hCAFEF00D;
            end
            if (c == RD_ACK_CYC + WR_WAIT + 4) stb = 1'b0;
            #2;
            if (ack === 1'b1) acks++;
            if (sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) clash++;
            if (c == RD_ACK_CYC + 1) begin
                n_cmp++;
                if (sram_ce_n !== 1'b1 || ack !== 1'b0 || sram_dq_oe !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap: ce_n=%b ack=%b dq_oe=%b want 1 0 0", sram_ce_n, ack, sram_dq_oe);
                end
            end
            if (c == RD_ACK_CYC + 2) begin
                n_cmp++;
                if (sram_dq_oe !== 1'b1 || sram_addr !== 18'h00022) begin
                    n_bad++;
                    $display("FAIL b2b_write_start: dq_oe=%b addr=%h want 1 00022", sram_dq_oe, sram_addr);
                end
            end
            if (c == RD_ACK_CYC + WR_WAIT + 3) begin
                n_cmp++;
                if (ack !== 1'b1 || sram_dq_out !== 32'hCAFEF00D) begin
                    n_bad++;
                    $display("FAIL b2b_write_ack: ack=%b dq=%h want 1 cafef00d", ack, sram_dq_out);
                end
            end
        end
        n_cmp++;
        if (acks != 2) begin
            n_bad++;
            $display("FAIL b2b_ack_count: got %0d want 2", acks);
        end
        n_cmp++;
        if (clash != 0) begin
            n_bad++;
            $display("FAIL b2b_bus_clash: got %0d cycles want 0", clash);
        end
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        cyc();
        stb = 1'b1; we = 1'b1; addr = 18'h00155; data_in = 32'h0BADF00D;
        #2;
        cyc(); #2;
        cyc(); rst = 1'b1; #2;
        n_cmp++;
        if (sram_we_n !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pulse_active: we_n=%b want 0", sram_we_n);
        end
        cyc(); rst = 1'b0; stb = 1'b0; #2;
        n_cmp++;
        if ({ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 5'b01110) begin
            n_bad++;
            $display("FAIL abort_idle: ack/ce/oe/we/dq_oe=%b want 01110",
                     {ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        for (int c = 0; c < 6; c++) begin
            cyc(); #2;
            if (ack === 1'b1) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL abort_no_ack: got %0d acks want 0", acks);
        end
        cyc();
        stb = 1'b1; we = 1'b0; addr = 18'h00007; sram_dq_in = 32'h13579BDF;
        #2;
        for (int c = 1; c <= RD_ACK_CYC + 1; c++) begin
            cyc();
            if (c == RD_ACK_CYC + 1) stb = 1'b0;
            #2;
            n_cmp++;
            if (ack !== (c == RD_ACK_CYC)) begin
                n_bad++;
                $display("FAIL abort_reread_ack cyc%0d: got %b want %b", c, ack, c == RD_ACK_CYC);
            end
            if (c == RD_ACK_CYC) begin
                n_cmp++;
                if (data_out !== 32'h13579BDF || sram_addr !== 18'h00007) begin
                    n_bad++;
                    $display("FAIL abort_reread_data: data=%h addr=%h want 13579bdf 00007", data_out, sram_addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 18: SRAM word-address width.
REQ-002 SHALL have parameter RD_WAIT, default 2, range 0..15: extra read cycles.
REQ-003 SHALL have parameter WR_WAIT, default 2, range 1..15: cycles sram_we_n is held low.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stb  in  1  bus request; held high by the master until ack.
REQ-007 we  in  1  1 = word write, 0 = word read.
REQ-008 addr  in  AW  word address (bus address bits [AW+1:2]).
REQ-009 data_in  in  32  write data from the bus.
REQ-010 data_out  out  32  read data to the bus.
REQ-011 ack  out  1  one-cycle completion pulse.
REQ-012 sram_addr  out  AW  SRAM address.
REQ-013 sram_dq_in  in  32  SRAM data pins, input side.
REQ-014 sram_dq_out  out  32  SRAM data pins, output side.
REQ-015 sram_dq_oe  out  1  1 = drive sram_dq_out onto the pins.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-017 The FSM SHALL have these states: IDLE, RD, RD_ACK (macro only), WR_SETUP, WR_PULSE, WR_HOLD.
REQ-018 In IDLE, the request SHALL be accepted when stb=1; addr and data_in are registered and the wait counter is loaded.
- we=0: go to RD, counter loaded with RD_WAIT.
- we=1: go to WR_SETUP, counter loaded with WR_WAIT-1.
REQ-019 All sram_* outputs SHALL be decoded from registered state and registered address/data only; there SHALL be no combinational path from stb, we or addr.
REQ-020 In RD:
- sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
- Counter decrements each cycle.
- Last RD cycle is the cycle with counter==0.
REQ-021 Read timing without the macro: if stb is accepted in cycle 0, ack=1 in cycle RD_WAIT+1 (the last RD cycle), with data_out=sram_dq_in; the next state is IDLE.
REQ-022 WR_SETUP (1 cycle):
- sram_ce_n=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=1.
- sram_dq_out = latched data.
REQ-023 WR_PULSE:
- Same as WR_SETUP except sram_we_n=0.
- Lasts exactly WR_WAIT cycles, then goes to WR_HOLD.
REQ-024 WR_HOLD (1 cycle):
- sram_we_n=1, sram_ce_n=0, sram_dq_oe=1, data still driven.
- ack=1; next state is IDLE.
- Write ack falls in cycle WR_WAIT+2.
REQ-025 In IDLE, ce_n, oe_n and we_n SHALL all be 1 and sram_dq_oe=0; sram_dq_oe SHALL never be 1 while sram_oe_n=0.
REQ-026 ack SHALL be exactly one cycle per request.
- stb still high in the cycle after ack is a new request; it is accepted from IDLE.
- This yields exactly one idle cycle between back-to-back transfers (the read-then-write sequence of a byte or halfword store).
REQ-027 data_out is a don't-care when ack=0.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state:
- ack=0; ce_n, oe_n and we_n = 1; sram_dq_oe=0.
- Counter = 0; data_out register = 0.
- Any transfer in progress is abandoned without ack, including during WR_PULSE (we_n rises at that edge).
REQ-029 A request with stb=1 during reset SHALL be accepted only from the first non-reset edge.

Configuration
REQ-030 Macro SRAM_CTRL_RD_REG_EN controls read-data registering.
- Defined: in the last RD cycle, sram_dq_in is captured into a 32-bit register, then the FSM goes to RD_ACK. RD_ACK drives all strobes inactive, ack=1 and data_out=register; read ack falls in cycle RD_WAIT+2.
- Undefined: RD_ACK and the register are absent, and REQ-021 applies.
- Write timing SHALL be identical in both builds.

Verification
REQ-031 Read, defaults, macro undefined: stb=1, we=0, addr=0x00010, sram_dq_in=0xDEADBEEF -> sram_addr=0x00010 and oe_n=0 in cycles 1-3; ack=1 with data_out=0xDEADBEEF in cycle 3 only.
REQ-032 Same read, macro defined -> ack in cycle 4 with data_out=0xDEADBEEF, even if sram_dq_in changes to 0 in cycle 4.
REQ-033 Write, WR_WAIT=2: data_in=0x12345678, addr=0x3FFFF -> dq_oe=1 in cycles 1-4; we_n=0 in cycles 2-3 only; ack in cycle 4; dq=0x12345678 throughout.
REQ-034 Read acked, stb held, we switched to 1 (byte-store sequence) -> one IDLE cycle, then write accepted; exactly two acks total; dq_oe and oe_n never both active.
REQ-035 rst=1 asserted in cycle 2 of a write -> we_n=1, dq_oe=0 and state IDLE at the next edge; no ack; a later read completes normally.
